// File: rtl/spike_input_arbiter_if.sv
// Spike arbiter bus: HLS and recurrent request channels, router output channel and statistics.
// The master side drives the requests and router ready; the slave side is the arbiter.
interface spike_input_arbiter_if #(
  parameter int unsigned NEURON_ID_WIDTH = 8,
  parameter int unsigned WEIGHT_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH       = 32
);
  logic                       hls_valid;
  logic [NEURON_ID_WIDTH-1:0] hls_neuron_id;
  logic [WEIGHT_WIDTH-1:0]    hls_weight;
  logic                       hls_ready;
  logic                       rec_valid;
  logic [NEURON_ID_WIDTH-1:0] rec_neuron_id;
  logic                       rec_ready;
  logic                       rec_enable;
  logic                       m_valid;
  logic [NEURON_ID_WIDTH-1:0] m_neuron_id;
  logic [WEIGHT_WIDTH-1:0]    m_weight;
  logic                       m_src;
  logic                       m_ready;
  logic [CNT_WIDTH-1:0]       hls_grant_count;
  logic [CNT_WIDTH-1:0]       rec_grant_count;
  logic [CNT_WIDTH-1:0]       rec_drop_count;
  logic                       arb_state;

  modport master (
    output hls_valid, hls_neuron_id, hls_weight, rec_valid, rec_neuron_id, rec_enable, m_ready,
    input  hls_ready, rec_ready, m_valid, m_neuron_id, m_weight, m_src,
    input  hls_grant_count, rec_grant_count, rec_drop_count, arb_state
  );

  modport slave (
    input  hls_valid, hls_neuron_id, hls_weight, rec_valid, rec_neuron_id, rec_enable, m_ready,
    output hls_ready, rec_ready, m_valid, m_neuron_id, m_weight, m_src,
    output hls_grant_count, rec_grant_count, rec_drop_count, arb_state
  );
endinterface

// File: rtl/spike_input_arbiter.sv
// Two-way spike arbiter: HLS has priority, but a burst limit forces a recurrent grant so the
// neuron array cannot starve. Single registered output word toward the router.
module spike_input_arbiter #(
  parameter int unsigned NEURON_ID_WIDTH = 8,
  parameter int unsigned WEIGHT_WIDTH    = 8,
  parameter int unsigned MAX_BURST       = 4,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input logic                  clk,
  input logic                  rst,
  spike_input_arbiter_if.slave bus_io
);

  localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);

  typedef enum logic {StPrioHls = 1'b0, StForceRec = 1'b1} state_e;

  state_e                     state_q;
  logic [BurstW-1:0]          burst_q;
  logic                       m_valid_q;
  logic [NEURON_ID_WIDTH-1:0] m_neuron_id_q;
  logic [WEIGHT_WIDTH-1:0]    m_weight_q;
  logic                       m_src_q;
  logic [CNT_WIDTH-1:0]       hls_cnt_q, rec_cnt_q, drop_cnt_q;

  logic slot_free, rec_pend, rec_drop, grant_hls, grant_rec;

  always_comb begin
    slot_free = ~m_valid_q | bus_io.m_ready;
    rec_pend  = bus_io.rec_valid & bus_io.rec_enable;
    rec_drop  = bus_io.rec_valid & ~bus_io.rec_enable;
    grant_hls = 1'b0;
    grant_rec = 1'b0;
    if (slot_free) begin
      if (state_q == StPrioHls) begin
        grant_hls = bus_io.hls_valid;
        grant_rec = ~bus_io.hls_valid & rec_pend;
      end else begin
        grant_rec = rec_pend;
        grant_hls = ~rec_pend & bus_io.hls_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StPrioHls;
      burst_q       <= '0;
      m_valid_q     <= 1'b0;
      m_neuron_id_q <= '0;
      m_weight_q    <= '0;
      m_src_q       <= 1'b0;
      hls_cnt_q     <= '0;
      rec_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      // Burst tracking only advances while a recurrent spike is actually waiting.
      if (grant_hls && rec_pend) begin
        if (state_q == StPrioHls && burst_q == BurstLast) begin
          state_q <= StForceRec;
          burst_q <= '0;
        end else begin
          burst_q <= burst_q + BurstW'(1);
        end
      end else if (grant_rec || !rec_pend) begin
        burst_q <= '0;
      end

      if (state_q == StForceRec && (grant_rec || !rec_pend)) begin
        state_q <= StPrioHls;
      end

      if (grant_hls) begin
        m_valid_q     <= 1'b1;
        m_neuron_id_q <= bus_io.hls_neuron_id;
        m_weight_q    <= bus_io.hls_weight;
        m_src_q       <= 1'b0;
        hls_cnt_q     <= hls_cnt_q + CNT_WIDTH'(1);
      end else if (grant_rec) begin
        m_valid_q     <= 1'b1;
        m_neuron_id_q <= bus_io.rec_neuron_id;
        m_weight_q    <= '0;
        m_src_q       <= 1'b1;
        rec_cnt_q     <= rec_cnt_q + CNT_WIDTH'(1);
      end else if (bus_io.m_ready) begin
        m_valid_q <= 1'b0;
      end

      if (rec_drop) begin
        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus_io.hls_ready       = grant_hls;
  assign bus_io.rec_ready       = grant_rec | rec_drop;
  assign bus_io.m_valid         = m_valid_q;
  assign bus_io.m_neuron_id     = m_neuron_id_q;
  assign bus_io.m_weight        = m_weight_q;
  assign bus_io.m_src           = m_src_q;
  assign bus_io.hls_grant_count = hls_cnt_q;
  assign bus_io.rec_grant_count = rec_cnt_q;
  assign bus_io.rec_drop_count  = drop_cnt_q;
  assign bus_io.arb_state       = state_q;

endmodule
